// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port Memory_File arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned STAT_W     = 16;
    localparam int unsigned CNT_W      = 3;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; on a tie the port that did not win last time wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       win,
    output logic       any
);

    always_comb begin
        any = |req;
        win = PORT_A;
        if (&req) begin
            win = ~last;
        end else if (req[PORT_B]) begin
            win = PORT_B;
        end
    end

endmodule

// File: rtl/memory_file_arbiter.sv
// Round-robin sharing of one Memory_File between a fetch port (A) and a load/store port (B).
// Optional saturating grant/conflict statistics are built when ARB_STATS_EN is defined.
module memory_file_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned MEM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_read_select,
    output logic [ADDR_W-1:0] mem_write_select,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [STAT_W-1:0] stat_gnt_a,
    output logic [STAT_W-1:0] stat_gnt_b,
    output logic [STAT_W-1:0] stat_conflict
);

    arb_state_e        state_q;
    logic              last_q;
    logic              owner_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [1:0]        req_c;
    logic              win_c;
    logic              any_c;
    logic              sel_we_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;

    assign req_c       = {b_req, a_req};
    assign sel_we_c    = (win_c == PORT_B) ? b_we    : a_we;
    assign sel_addr_c  = (win_c == PORT_B) ? b_addr  : a_addr;
    assign sel_wdata_c = (win_c == PORT_B) ? b_wdata : a_wdata;

    rr_arb2 u_rr_arb2 (
        .req  (req_c),
        .last (last_q),
        .win  (win_c),
        .any  (any_c)
    );

    // Sequencer: the winner's fields go straight into the memory-side registers at grant time.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            last_q           <= PORT_B;
            owner_q          <= PORT_A;
            cnt_q            <= '0;
            a_gnt            <= 1'b0;
            b_gnt            <= 1'b0;
            a_rvalid         <= 1'b0;
            b_rvalid         <= 1'b0;
            rdata            <= '0;
            mem_read_select  <= '0;
            mem_write_select <= '0;
            mem_write_data   <= '0;
            mem_write_enable <= 1'b0;
        end else begin
            a_gnt            <= 1'b0;
            b_gnt            <= 1'b0;
            a_rvalid         <= 1'b0;
            b_rvalid         <= 1'b0;
            mem_write_enable <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_c) begin
                        owner_q <= win_c;
                        last_q  <= win_c;
                        a_gnt   <= (win_c == PORT_A);
                        b_gnt   <= (win_c == PORT_B);
                        if (sel_we_c) begin
                            mem_write_enable <= 1'b1;
                            mem_write_select <= sel_addr_c;
                            mem_write_data   <= sel_wdata_c;
                            state_q          <= ST_WR;
                        end else begin
                            mem_read_select <= sel_addr_c;
                            cnt_q           <= CNT_W'(MEM_RD_LAT);
                            state_q         <= ST_RD;
                        end
                    end
                end
                ST_WR: begin
                    state_q <= ST_IDLE;
                end
                ST_RD: begin
                    if (cnt_q == '0) begin
                        rdata    <= mem_read_data;
                        a_rvalid <= (owner_q == PORT_A);
                        b_rvalid <= (owner_q == PORT_B);
                        state_q  <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] gnt_a_q;
    logic [STAT_W-1:0] gnt_b_q;
    logic [STAT_W-1:0] conflict_q;
    logic              grant_c;

    assign grant_c = (state_q == ST_IDLE) && any_c;

    // Saturating counters, sampled on the same IDLE decision that issues the grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            gnt_a_q    <= '0;
            gnt_b_q    <= '0;
            conflict_q <= '0;
        end else if (grant_c) begin
            if ((win_c == PORT_A) && (gnt_a_q != '1)) begin
                gnt_a_q <= gnt_a_q + STAT_W'(1);
            end
            if ((win_c == PORT_B) && (gnt_b_q != '1)) begin
                gnt_b_q <= gnt_b_q + STAT_W'(1);
            end
            if ((&req_c) && (conflict_q != '1)) begin
                conflict_q <= conflict_q + STAT_W'(1);
            end
        end
    end

    assign stat_gnt_a    = gnt_a_q;
    assign stat_gnt_b    = gnt_b_q;
    assign stat_conflict = conflict_q;
`else
    assign stat_gnt_a    = '0;
    assign stat_gnt_b    = '0;
    assign stat_conflict = '0;
`endif

endmodule

// File: tb/tb_memory_file_arbiter.sv
// Bench for memory_file_arbiter: directed scenarios plus random traffic against a shadow-memory model,
// with extra instances at read latencies 0 and 3.
module tb_memory_file_arbiter;

    localparam int unsigned M_LAT = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, b_addr, a_wdata, b_wdata;

    logic        m_a_gnt, m_b_gnt, m_a_rvalid, m_b_rvalid, m_mwe;
    logic [31:0] m_rdata, m_mrs, m_mws, m_mwd, m_mrd;
    logic [15:0] m_sga, m_sgb, m_scf;
    logic        z_a_gnt, z_b_gnt, z_a_rvalid, z_b_rvalid, z_mwe;
    logic [31:0] z_rdata, z_mrs, z_mws, z_mwd, z_mrd;
    logic [15:0] z_sga, z_sgb, z_scf;
    logic        t_a_gnt, t_b_gnt, t_a_rvalid, t_b_rvalid, t_mwe;
    logic [31:0] t_rdata, t_mrs, t_mws, t_mwd, t_mrd;
    logic [15:0] t_sga, t_sgb, t_scf;

    logic [31:0] m_mem [16];
    logic [31:0] z_mem [16];
    logic [31:0] t_mem [16];
    logic [31:0] m_p1, t_p1, t_p2, t_p3;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sh [16];
    logic        exp_last;
    logic [31:0] exp_rdata;
    int          cga, cgb, ccf;

    always #5 clk = ~clk;

    memory_file_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_RD_LAT(1)) u_dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(m_a_gnt), .b_gnt(m_b_gnt), .a_rvalid(m_a_rvalid), .b_rvalid(m_b_rvalid),
        .rdata(m_rdata), .mem_read_select(m_mrs), .mem_write_select(m_mws),
        .mem_write_data(m_mwd), .mem_write_enable(m_mwe), .mem_read_data(m_mrd),
        .stat_gnt_a(m_sga), .stat_gnt_b(m_sgb), .stat_conflict(m_scf)
    );

    memory_file_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_RD_LAT(0)) u_dut_lat0 (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(z_a_gnt), .b_gnt(z_b_gnt), .a_rvalid(z_a_rvalid), .b_rvalid(z_b_rvalid),
        .rdata(z_rdata), .mem_read_select(z_mrs), .mem_write_select(z_mws),
        .mem_write_data(z_mwd), .mem_write_enable(z_mwe), .mem_read_data(z_mrd),
        .stat_gnt_a(z_sga), .stat_gnt_b(z_sgb), .stat_conflict(z_scf)
    );

    memory_file_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_RD_LAT(3)) u_dut_lat3 (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(t_a_gnt), .b_gnt(t_b_gnt), .a_rvalid(t_a_rvalid), .b_rvalid(t_b_rvalid),
        .rdata(t_rdata), .mem_read_select(t_mrs), .mem_write_select(t_mws),
        .mem_write_data(t_mwd), .mem_write_enable(t_mwe), .mem_read_data(t_mrd),
        .stat_gnt_a(t_sga), .stat_gnt_b(t_sgb), .stat_conflict(t_scf)
    );

    // Memory_File models: synchronous write, read data delayed by the instance's latency.
    always @(posedge clk) begin
        if (m_mwe) m_mem[m_mws[3:0]] <= m_mwd;
        if (z_mwe) z_mem[z_mws[3:0]] <= z_mwd;
        if (t_mwe) t_mem[t_mws[3:0]] <= t_mwd;
        m_p1 <= m_mem[m_mrs[3:0]];
        t_p1 <= t_mem[t_mrs[3:0]];
        t_p2 <= t_p1;
        t_p3 <= t_p2;
    end
    assign m_mrd = m_p1;
    assign z_mrd = z_mem[z_mrs[3:0]];
    assign t_mrd = t_p3;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input string tag);
`ifdef ARB_STATS_EN
        chk({tag, "_stat_gnt_a"}, 64'(m_sga), 64'(cga));
        chk({tag, "_stat_gnt_b"}, 64'(m_sgb), 64'(cgb));
        chk({tag, "_stat_conflict"}, 64'(m_scf), 64'(ccf));
`else
        chk({tag, "_stat_gnt_a"}, 64'(m_sga), 64'(0));
        chk({tag, "_stat_gnt_b"}, 64'(m_sgb), 64'(0));
        chk({tag, "_stat_conflict"}, 64'(m_scf), 64'(0));
`endif
    endtask

    // One transaction on the latency-1 instance, started while it is idle.
    task automatic run(input bit ar, input bit awe, input logic [3:0] aad, input logic [31:0] ad,
                       input bit br, input bit bwe, input logic [3:0] bad, input logic [31:0] bd);
        bit          win;
        bit          we;
        logic [3:0]  ea;
        logic [31:0] ed;
        a_req = ar; a_we = awe; a_addr = {28'h0, aad}; a_wdata = ad;
        b_req = br; b_we = bwe; b_addr = {28'h0, bad}; b_wdata = bd;
        if (!ar && !br) begin
            tick();
            return;
        end
        win = (ar && br) ? !exp_last : br;
        we  = win ? bwe : awe;
        ea  = win ? bad : aad;
        ed  = win ? bd  : ad;
        if (win) cgb++; else cga++;
        if (ar && br) ccf++;
        tick();
        chk("gnt_a", 64'(m_a_gnt), 64'(!win));
        chk("gnt_b", 64'(m_b_gnt), 64'(win));
        chk("rdata_held", 64'(m_rdata), 64'(exp_rdata));
        a_req = 1'b0; b_req = 1'b0;
        exp_last = win;
        if (we) begin
            chk("wr_enable", 64'(m_mwe), 64'(1));
            chk("wr_select", 64'(m_mws), 64'(ea));
            chk("wr_data", 64'(m_mwd), 64'(ed));
            sh[ea] = ed;
            tick();
            chk("wr_enable_off", 64'(m_mwe), 64'(0));
            chk("no_gnt_after_wr", 64'({m_a_gnt, m_b_gnt}), 64'(0));
        end else begin
            for (int k = 0; k <= int'(M_LAT); k++) begin
                chk("rvalid_early", 64'({m_a_rvalid, m_b_rvalid}), 64'(0));
                chk("rd_select", 64'(m_mrs), 64'(ea));
                tick();
            end
            chk("rvalid_a", 64'(m_a_rvalid), 64'(!win));
            chk("rvalid_b", 64'(m_b_rvalid), 64'(win));
            chk("rdata", 64'(m_rdata), 64'(sh[ea]));
            exp_rdata = sh[ea];
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_mem[i] = '0; z_mem[i] = '0; t_mem[i] = '0; sh[i] = '0;
        end
        exp_last = 1'b1; exp_rdata = '0; cga = 0; cgb = 0; ccf = 0;
        a_req = 1'b1; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        reset = 1'b0;

        // Reset held with a pending request
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rst_gnt", 64'({m_a_gnt, m_b_gnt}), 64'(0));
            chk("rst_wr_enable", 64'(m_mwe), 64'(0));
            chk("rst_rdata", 64'(m_rdata), 64'(0));
            chk_stats("rst");
        end
        a_req = 1'b0;
        reset = 1'b1;
        tick();

        // Single write then read from A
        run(1, 1, 4'd3, 32'hDEAD_BEEF, 0, 0, 4'd0, 32'h0);
        run(1, 0, 4'd3, 32'h0, 0, 0, 4'd0, 32'h0);

        // Back-to-back: B read requested in A's rvalid cycle
        run(1, 1, 4'd7, 32'h0000_CAFE, 0, 0, 4'd0, 32'h0);
        run(0, 0, 4'd0, 32'h0, 1, 1, 4'd4, 32'h1234_5678);
        run(1, 0, 4'd3, 32'h0, 0, 0, 4'd0, 32'h0);
        run(0, 0, 4'd0, 32'h0, 1, 0, 4'd4, 32'h0);

        // Contention: both ports write continuously, grants alternate starting with A
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'd6; a_wdata = 32'h66;
        b_req = 1'b1; b_we = 1'b1; b_addr = 32'd5; b_wdata = 32'h55;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k % 2 == 0) begin
                chk("cont_gnt_a", 64'(m_a_gnt), 64'((k / 2) % 2 == 0));
                chk("cont_gnt_b", 64'(m_b_gnt), 64'((k / 2) % 2 == 1));
                chk("cont_wr_enable", 64'(m_mwe), 64'(1));
                if (k == 6) begin
                    a_req = 1'b0; b_req = 1'b0;
                end
            end else begin
                chk("cont_idle_gnt", 64'({m_a_gnt, m_b_gnt}), 64'(0));
                chk("cont_idle_wr", 64'(m_mwe), 64'(0));
            end
        end
        cga += 2; cgb += 2; ccf += 4; exp_last = 1'b1;
        sh[5] = 32'h55; sh[6] = 32'h66;
        chk_stats("cont");
        run(0, 0, 4'd0, 32'h0, 1, 0, 4'd5, 32'h0);
        run(1, 0, 4'd6, 32'h0, 0, 0, 4'd0, 32'h0);

        // Reset during a read abandons it
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'd3;
        tick();
        chk("midrd_gnt", 64'(m_a_gnt), 64'(1));
        a_req = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_last = 1'b1; exp_rdata = '0; cga = 0; cgb = 0; ccf = 0;
        for (int k = 0; k < 3; k++) begin
            chk("midrd_no_rvalid", 64'({m_a_rvalid, m_b_rvalid}), 64'(0));
            chk("midrd_rdata", 64'(m_rdata), 64'(0));
            chk("midrd_wr_enable", 64'(m_mwe), 64'(0));
            tick();
        end
        chk_stats("midrd");
        run(0, 0, 4'd0, 32'h0, 1, 0, 4'd3, 32'h0);
        run(1, 0, 4'd7, 32'h0, 1, 0, 4'd3, 32'h0);

        // Random traffic against the shadow model
        for (int it = 0; it < 60; it++) begin
            bit ar, br;
            ar = 1'($urandom_range(0, 1));
            br = 1'($urandom_range(0, 1));
            if (!ar && !br) ar = 1'b1;
            run(ar, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                br, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
        end
        chk_stats("rand");

        // Read latency 0 and 3 instances
        a_req = 1'b0; b_req = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'd9; a_wdata = 32'hA5A5_0009;
        tick();
        chk("lat0_wr_gnt", 64'(z_a_gnt), 64'(1));
        chk("lat3_wr_gnt", 64'(t_a_gnt), 64'(1));
        a_req = 1'b0;
        tick();
        a_req = 1'b1; a_we = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin
                chk("lat0_rd_gnt", 64'(z_a_gnt), 64'(1));
                chk("lat3_rd_gnt", 64'(t_a_gnt), 64'(1));
                a_req = 1'b0;
            end
            chk("lat0_rvalid", 64'(z_a_rvalid), 64'(k == 2));
            chk("lat3_rvalid", 64'(t_a_rvalid), 64'(k == 5));
            if (k == 2) chk("lat0_rdata", 64'(z_rdata), 64'(32'hA5A5_0009));
            if (k == 5) chk("lat3_rdata", 64'(t_rdata), 64'(32'hA5A5_0009));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
